spi_master: RTL and testbench



---
 rtl/qs_spi_pkg.sv | 21 ++
 rtl/spi_phase_timer.sv | 29 ++
 rtl/spi_master.sv | 126 ++++++++++++
 tb/tb_spi_master.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/qs_spi_pkg.sv
// rtl/qs_spi_pkg.sv - shared defaults, frame field offsets and FSM states for the quad-stepper SPI link
package qs_spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 64;
  localparam int CLK_DIV_DEFAULT    = 4;

  // Host-to-device: step period in the low word.
  // Device-to-host: count in the high word, position in the low word.
  localparam int STEP_PERIOD_LSB = 0;
  localparam int POSITION_LSB    = 0;
  localparam int COUNT_LSB       = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - reloadable down-counter that times every SPI phase
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  // Loading CLK_DIV-1 makes the phase that starts on the load edge last CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 MSB-first SPI initiator exchanging one FRAME_BITS word per transfer
module spi_master
  import qs_spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int CLK_DIV    = CLK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ssel
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS);

  // Below 3 the synchronized miso sample would fall before the slave's data settles.
  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be within 3..255");
  end

  logic                  miso_meta;
  logic                  miso_sync;
  spi_state_t            state;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [CW-1:0]         bit_cnt;
  logic                  timer_load;
  logic                  phase_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  assign timer_load = (state == IDLE) ? start : phase_done;

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .tc    (phase_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ssel     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[FRAME_BITS-1];
            ssel     <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_done) begin
            sck   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          // Sample late in the high phase, then present the next bit as sck falls.
          if (phase_done) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], miso_sync};
            bit_cnt  <= bit_cnt + 1'b1;
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            mosi     <= tx_shift[FRAME_BITS-2];
            sck      <= 1'b0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_done) begin
            if (bit_cnt == LAST_BIT) begin
              ssel    <= 1'b1;
              mosi    <= 1'b0;
              rx_data <= rx_shift;
              done    <= 1'b1;
              state   <= GAP;
            end else begin
              sck   <= 1'b1;
              state <= HIGH;
            end
          end
        end
        GAP: begin
          if (phase_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master against a behavioural mode-0 slave
module tb_spi_master;

  localparam int FB       = 64;
  localparam int CD       = 4;
  localparam int FB8      = 8;
  localparam int CD8      = 3;
  localparam int SSEL_LOW = CD * (1 + 2 * FB);
  localparam int SPACING  = CD * (2 + 2 * FB) + 1;
  localparam int LIMIT    = 4000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [FB-1:0] tx_data;
  logic [FB-1:0] rx_data;
  logic          busy, done, sck, mosi, miso, ssel;
  logic          loop;
  logic          slave_miso;

  logic           start8;
  logic [FB8-1:0] tx8, rx8;
  logic           busy8, done8, sck8, mosi8, miso8, ssel8;

  assign miso  = loop ? mosi : slave_miso;
  assign miso8 = mosi8;

  spi_master #(.FRAME_BITS(FB), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel)
  );

  spi_master #(.FRAME_BITS(FB8), .CLK_DIV(CD8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tx_data(tx8), .rx_data(rx8),
    .busy(busy8), .done(done8), .sck(sck8), .mosi(mosi8), .miso(miso8), .ssel(ssel8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural mode-0 slave: presents MSB on select, captures on sck rise, shifts on sck fall.
  logic [63:0] slave_tx_word = '0;
  logic [63:0] slave_out     = '0;
  logic [63:0] slave_in      = '0;
  logic        slave_sel_prev = 1'b1;
  initial slave_miso = 1'b0;

  always @(negedge ssel or posedge ssel or negedge sck) begin
    if (ssel === 1'b1) begin
      slave_sel_prev = 1'b1;
    end else if (slave_sel_prev) begin
      slave_out      = slave_tx_word;
      slave_sel_prev = 1'b0;
    end else begin
      slave_out = {slave_out[62:0], 1'b0};
    end
    slave_miso = slave_out[63];
  end

  always @(posedge sck) if (ssel === 1'b0) slave_in = {slave_in[62:0], mosi};

  int   cyc = 0;
  int   ssel_low_cyc = 0, sck_rises = 0, done_cnt = 0;
  int   ssel8_low = 0, sck8_rises = 0, done8_cnt = 0;
  logic sck_prev = 1'b0, ssel_prev = 1'b1, sck8_prev = 1'b0;
  int   fall_q[$];
  int   rise_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ssel === 1'b0) ssel_low_cyc++;
    if (sck === 1'b1 && sck_prev === 1'b0) sck_rises++;
    if (done === 1'b1) done_cnt++;
    if (ssel === 1'b0 && ssel_prev === 1'b1) fall_q.push_back(cyc);
    if (ssel === 1'b1 && ssel_prev === 1'b0) rise_q.push_back(cyc);
    if (ssel8 === 1'b0) ssel8_low++;
    if (sck8 === 1'b1 && sck8_prev === 1'b0) sck8_rises++;
    if (done8 === 1'b1) done8_cnt++;
    sck_prev  = sck;
    ssel_prev = ssel;
    sck8_prev = sck8;
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, 64'(n < LIMIT), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_busy_drop"}, 64'(n < 100), 64'd1);
  endtask

  task automatic wait_rises(input string tag, input int base, input int target);
    int n = 0;
    while (sck_rises - base < target && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_rise_seen"}, 64'(n < LIMIT), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [63:0] tx, input logic [63:0] sw,
                           input logic lp);
    int low0, rise0, done0;
    loop = lp; slave_tx_word = sw; tx_data = tx;
    low0 = ssel_low_cyc; rise0 = sck_rises; done0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(tag);
    wait_idle(tag);
    check({tag, "_rx"}, rx_data, lp ? tx : sw);
    check({tag, "_ssel_low"}, 64'(ssel_low_cyc - low0), 64'(SSEL_LOW));
    check({tag, "_sck_rises"}, 64'(sck_rises - rise0), 64'(FB));
    check({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
    if (!lp) check({tag, "_slave_rx"}, slave_in, tx);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, c;
    int f0, r0, d0, low8, rise8, n;

    rst_n = 1'b1; start = 1'b0; tx_data = '0; loop = 1'b1; start8 = 1'b0; tx8 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssel", 64'(ssel), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rx", rx_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("loop_deadbeef", 64'hDEADBEEF_01234567, 64'd0, 1'b1);
    run_frame("slave_step", 64'h0000_0000_0000_1388, 64'h00000010_FFFFFFF0, 1'b0);
    check("slave_step_period", 64'(slave_in[31:0]), 64'h1388);

    for (int i = 0; i < 4; i++) begin
      run_frame("rand", {$urandom(), $urandom()}, {$urandom(), $urandom()}, i[0]);
    end

    // Back-to-back with start held high.
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    loop = 1'b1; tx_data = a; f0 = fall_q.size(); r0 = rise_q.size();
    @(negedge clk); start = 1'b1;
    wait_done("b2b_first");
    check("b2b_first_rx", rx_data, a);
    tx_data = b;
    @(negedge clk);
    wait_done("b2b_second");
    start = 1'b0;
    check("b2b_second_rx", rx_data, b);
    wait_idle("b2b");
    check("b2b_frames", 64'(fall_q.size() - f0), 64'd2);
    if (fall_q.size() >= f0 + 2 && rise_q.size() >= r0 + 1) begin
      check("b2b_ssel_gap", 64'(fall_q[f0 + 1] - rise_q[r0]), 64'(CD + 1));
      check("b2b_spacing", 64'(fall_q[f0 + 1] - fall_q[f0]), 64'(SPACING));
    end

    // start pulsed during bit 10 is ignored.
    c = {$urandom(), $urandom()};
    loop = 1'b1; tx_data = c; f0 = fall_q.size(); r0 = sck_rises;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rises("mid_start", r0, 11);
    tx_data = ~c; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("mid_start");
    check("mid_start_rx", rx_data, c);
    wait_idle("mid_start");
    repeat (20) @(negedge clk);
    check("mid_start_no_requeue", 64'(fall_q.size() - f0), 64'd1);
    check("mid_start_busy", 64'(busy), 64'd0);

    // Reset during bit 30.
    loop = 1'b1; tx_data = {$urandom(), $urandom()}; r0 = sck_rises; d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rises("mid_rst", r0, 31);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ssel", 64'(ssel), 64'd1);
    check("mid_rst_sck", 64'(sck), 64'd0);
    check("mid_rst_mosi", 64'(mosi), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rx", rx_data, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame("post_rst", {$urandom(), $urandom()}, 64'd0, 1'b1);

    // Narrow instance: 8-bit frame, CLK_DIV 3.
    tx8 = 8'hA5; low8 = ssel8_low; rise8 = sck8_rises; d0 = done8_cnt;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    check("f8_done_seen", 64'(n < LIMIT), 64'd1);
    repeat (CD8 + 2) @(negedge clk);
    check("f8_rx", 64'(rx8), 64'hA5);
    check("f8_ssel_low", 64'(ssel8_low - low8), 64'(CD8 * (1 + 2 * FB8)));
    check("f8_sck_rises", 64'(sck8_rises - rise8), 64'(FB8));
    check("f8_done_pulses", 64'(done8_cnt - d0), 64'd1);
    check("f8_busy", 64'(busy8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
